// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared constants and types for the 7-segment display blocks:
//                active-low segment patterns (bit6=a .. bit0=g), the blank
//                pattern and the scan state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // All segments off (active-low bus)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns for decimal digits 0..9
    localparam logic [6:0] c_SEG_0 = 7'b0000001;
    localparam logic [6:0] c_SEG_1 = 7'b1001111;
    localparam logic [6:0] c_SEG_2 = 7'b0010010;
    localparam logic [6:0] c_SEG_3 = 7'b0000110;
    localparam logic [6:0] c_SEG_4 = 7'b1001100;
    localparam logic [6:0] c_SEG_5 = 7'b0100100;
    localparam logic [6:0] c_SEG_6 = 7'b0100000;
    localparam logic [6:0] c_SEG_7 = 7'b0001111;
    localparam logic [6:0] c_SEG_8 = 7'b0000000;
    localparam logic [6:0] c_SEG_9 = 7'b0000100;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD nibble to active-low 7-segment pattern.
//                Non-decimal codes 10..15 produce a blank digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    // Table lookup; anything outside 0..9 is shown dark
    always_comb begin
        o_segments = SEG_BLANK;
        case (i_nibble)
            4'd0:    o_segments = c_SEG_0;
            4'd1:    o_segments = c_SEG_1;
            4'd2:    o_segments = c_SEG_2;
            4'd3:    o_segments = c_SEG_3;
            4'd4:    o_segments = c_SEG_4;
            4'd5:    o_segments = c_SEG_5;
            4'd6:    o_segments = c_SEG_6;
            4'd7:    o_segments = c_SEG_7;
            4'd8:    o_segments = c_SEG_8;
            4'd9:    o_segments = c_SEG_9;
            default: o_segments = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_mux
//  Description : Time-multiplexes DIGITS BCD nibbles plus decimal points onto
//                one active-low segment bus with active-low anode enables.
//                Each slot is CLK_DIV cycles: a SHOW phase followed by a
//                GHOST_CYCLES dead-time BLANK phase. Incoming values are held
//                in a pending buffer and committed to the displayed (shadow)
//                buffer only at frame boundaries, so frames never tear.
//                Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses zeros
//                above the most significant nonzero digit (digit 0 never).
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 50000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            segment,
    output logic                  dp,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame_done
);

    // Prescaler only ever holds 0..CLK_DIV-1, so clog2 bits are enough
    localparam int c_PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_PRESC_W-1:0] c_SHOW_LAST = c_PRESC_W'(CLK_DIV - GHOST_CYCLES - 1);
    localparam logic [c_PRESC_W-1:0] c_SLOT_LAST = c_PRESC_W'(CLK_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_LAST  = c_IDX_W'(DIGITS - 1);

    scan_state_t            r_state, w_state_nxt;
    logic [c_IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [c_PRESC_W-1:0]   r_presc, w_presc_nxt;
    logic                   w_slot_end;
    logic                   w_commit;
    logic                   w_frame_end;

    logic [4*DIGITS-1:0]    r_shadow_dig, w_shadow_dig_nxt;
    logic [DIGITS-1:0]      r_shadow_dp, w_shadow_dp_nxt;
    logic [4*DIGITS-1:0]    r_pend_dig;
    logic [DIGITS-1:0]      r_pend_dp;
    logic                   r_pend_valid;

    logic [3:0]             w_nibble;
    logic [6:0]             w_dec;
    logic [6:0]             w_seg_digit;

    logic [6:0]             r_segment;
    logic                   r_dp;
    logic [DIGITS-1:0]      r_anode;
    logic                   r_frame_done;

    // State, digit index and prescaler registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Next-state logic: phase sequencing, slot/frame ends and commit points
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_presc_nxt = r_presc;
        w_slot_end  = 1'b0;
        w_commit    = 1'b0;
        w_frame_end = 1'b0;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SHOW;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                    w_commit    = 1'b1;
                end
                SHOW: begin
                    // Slot-end test first: with no dead time SHOW fills the slot
                    if (r_presc == c_SLOT_LAST) begin
                        w_slot_end = 1'b1;
                    end else if (r_presc == c_SHOW_LAST) begin
                        w_state_nxt = BLANK;
                        w_presc_nxt = r_presc + c_PRESC_W'(1);
                    end else begin
                        w_presc_nxt = r_presc + c_PRESC_W'(1);
                    end
                end
                BLANK: begin
                    if (r_presc == c_SLOT_LAST) begin
                        w_slot_end = 1'b1;
                    end else begin
                        w_presc_nxt = r_presc + c_PRESC_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                end
            endcase
            if (w_slot_end) begin
                w_state_nxt = SHOW;
                w_presc_nxt = '0;
                if (r_idx == c_IDX_LAST) begin
                    w_idx_nxt   = '0;
                    w_frame_end = 1'b1;
                    w_commit    = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + c_IDX_W'(1);
                end
            end
        end
    end

    // Shadow selection: a load on a commit edge bypasses the pending buffer
    always_comb begin
        w_shadow_dig_nxt = r_shadow_dig;
        w_shadow_dp_nxt  = r_shadow_dp;
        if (w_commit && load) begin
            w_shadow_dig_nxt = digits_in;
            w_shadow_dp_nxt  = dp_in;
        end else if (w_commit && r_pend_valid) begin
            w_shadow_dig_nxt = r_pend_dig;
            w_shadow_dp_nxt  = r_pend_dp;
        end
    end

    // Pending and shadow buffers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_pend_dig   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_shadow_dig <= w_shadow_dig_nxt;
            r_shadow_dp  <= w_shadow_dp_nxt;
            if (load) begin
                r_pend_dig   <= digits_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= !w_commit;
            end else if (w_commit) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign w_nibble = w_shadow_dig_nxt[{w_idx_nxt, 2'b00} +: 4];

    seg7_decode u_decode (
        .i_nibble   (w_nibble),
        .o_segments (w_dec)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero
    logic [DIGITS-1:0] w_lz_blank;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_lz_lsd
                assign w_lz_blank[gi] = 1'b0;
            end else begin : g_lz_upper
                assign w_lz_blank[gi] = (w_shadow_dig_nxt[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate
    assign w_seg_digit = w_lz_blank[w_idx_nxt] ? SEG_BLANK : w_dec;
`else
    assign w_seg_digit = w_dec;
`endif

    // Registered outputs follow the state being entered, so they change
    // exactly on the edge where state or index changes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_segment    <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_anode      <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_state_nxt == SHOW) begin
                r_anode   <= ~(DIGITS'(1) << w_idx_nxt);
                r_segment <= w_seg_digit;
                r_dp      <= ~w_shadow_dp_nxt[w_idx_nxt];
            end else begin
                r_anode   <= '1;
                r_segment <= SEG_BLANK;
                r_dp      <= 1'b1;
            end
        end
    end

    assign segment    = r_segment;
    assign dp         = r_dp;
    assign anode      = r_anode;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
